// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// The optional carry-in feature (ADDER_SEQ_CARRY_IN_EN) is handled in the top.
package adder_seq_pkg;

    localparam int LIMB_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the limb index; never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl.sv
// Sequences one shared 8-bit adder over NBYTES cycles to build a wide add/sub with C/V/Z/N.
// Optional macro ADDER_SEQ_CARRY_IN_EN adds cin_ext for ADC/SBB behaviour.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef ADDER_SEQ_CARRY_IN_EN
    input  logic                       cin_ext,
`endif
    input  logic                       start,
    input  logic                       op_sub,
    input  logic [8*NBYTES-1:0]        opa,
    input  logic [8*NBYTES-1:0]        opb,
    output logic                       busy,
    output logic                       done,
    output logic [8*NBYTES-1:0]        result,
    output logic                       flag_c,
    output logic                       flag_v,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic [7:0]                 add_a,
    output logic [7:0]                 add_b,
    output logic                       add_cin,
    input  logic [7:0]                 add_sum,
    input  logic                       add_cout,
    input  logic                       add_cin_msb
);

    localparam int W     = LIMB_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           state_r;
    logic [W-1:0]     a_sh_r;
    logic [W-1:0]     b_sh_r;
    logic [W-1:0]     result_r;
    logic [IDX_W-1:0] idx_r;
    logic             busy_r;
    logic             done_r;
    logic             flag_c_r;
    logic             flag_v_r;
    logic             flag_z_r;
    logic             flag_n_r;
    logic [7:0]       add_a_r;
    logic [7:0]       add_b_r;
    logic             add_cin_r;

    logic [W-1:0]     b_in_s;
    logic             cin0_s;
    logic [W-1:0]     res_next_s;

    // Operand B conditioning and initial carry for a newly accepted request.
    always_comb begin
        b_in_s = {W{1'b0}};
        cin0_s = 1'b0;
        if (op_sub == OP_SUB) begin
            b_in_s = ~opb;
        end else begin
            b_in_s = opb;
        end
`ifdef ADDER_SEQ_CARRY_IN_EN
        cin0_s = op_sub ^ cin_ext;
`else
        cin0_s = op_sub;
`endif
    end

    // Result with the current adder sum merged into limb idx; lets Z/N be ready on done.
    always_comb begin
        res_next_s = result_r;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_r == IDX_W'(k)) begin
                res_next_s[k*LIMB_W +: LIMB_W] = add_sum;
            end else begin
                res_next_s[k*LIMB_W +: LIMB_W] = result_r[k*LIMB_W +: LIMB_W];
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            a_sh_r    <= {W{1'b0}};
            b_sh_r    <= {W{1'b0}};
            result_r  <= {W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            flag_c_r  <= 1'b0;
            flag_v_r  <= 1'b0;
            flag_z_r  <= 1'b0;
            flag_n_r  <= 1'b0;
            add_a_r   <= 8'h00;
            add_b_r   <= 8'h00;
            add_cin_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Limb 0 goes straight to the adder registers; the rest wait in the shifters.
                        add_a_r   <= opa[LIMB_W-1:0];
                        add_b_r   <= b_in_s[LIMB_W-1:0];
                        add_cin_r <= cin0_s;
                        a_sh_r    <= opa >> LIMB_W;
                        b_sh_r    <= b_in_s >> LIMB_W;
                        idx_r     <= {IDX_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        busy_r    <= 1'b0;
                        add_a_r   <= 8'h00;
                        add_b_r   <= 8'h00;
                        add_cin_r <= 1'b0;
                    end
                end
                RUN: begin
                    result_r <= res_next_s;
                    if (idx_r == LAST_IDX) begin
                        flag_c_r  <= add_cout;
                        flag_v_r  <= add_cout ^ add_cin_msb;
                        flag_z_r  <= (res_next_s == {W{1'b0}});
                        flag_n_r  <= res_next_s[W-1];
                        done_r    <= 1'b1;
                        idx_r     <= {IDX_W{1'b0}};
                        add_a_r   <= 8'h00;
                        add_b_r   <= 8'h00;
                        add_cin_r <= 1'b0;
                        state_r   <= DONE;
                    end else begin
                        add_a_r   <= a_sh_r[LIMB_W-1:0];
                        add_b_r   <= b_sh_r[LIMB_W-1:0];
                        add_cin_r <= add_cout;
                        a_sh_r    <= a_sh_r >> LIMB_W;
                        b_sh_r    <= b_sh_r >> LIMB_W;
                        idx_r     <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    idx_r     <= {IDX_W{1'b0}};
                    add_a_r   <= 8'h00;
                    add_b_r   <= 8'h00;
                    add_cin_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign flag_c  = flag_c_r;
    assign flag_v  = flag_v_r;
    assign flag_z  = flag_z_r;
    assign flag_n  = flag_n_r;
    assign add_a   = add_a_r;
    assign add_b   = add_b_r;
    assign add_cin = add_cin_r;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: models the parent's 8-bit adder and checks against wide arithmetic.
module tb_adder_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic         cin_ext;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_c, flag_v, flag_z, flag_n;
    logic [7:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout, add_cin_msb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ADDER_SEQ_CARRY_IN_EN
        .cin_ext     (cin_ext),
`endif
        .start       (start),
        .op_sub      (op_sub),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .add_cin_msb (add_cin_msb)
    );

    // The shared ripple adder that lives in the parent datapath.
    logic [8:0] full9;
    logic [7:0] low8;
    always_comb begin
        full9       = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
        low8        = {1'b0, add_a[6:0]} + {1'b0, add_b[6:0]} + {7'h00, add_cin};
        add_sum     = full9[7:0];
        add_cout    = full9[8];
        add_cin_msb = low8[7];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; poke re-pulses start during RUN and during DONE with other operands.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input logic poke);
        logic [W:0]   full;
        logic [W-1:0] exp_r;
        logic [W-1:0] br;
        logic         exp_c, exp_v, ce;
        int           cyc;
        ce = cin;
`ifndef ADDER_SEQ_CARRY_IN_EN
        ce = 1'b0;
`endif
        if (!sub) begin
            full  = {1'b0, a} + {1'b0, b} + (W+1)'(ce);
            exp_r = full[W-1:0];
            exp_c = full[W];
            exp_v = (a[W-1] == b[W-1]) && (exp_r[W-1] != a[W-1]);
        end else begin
            exp_r = a - b - W'(ce);
            exp_c = ({1'b0, a} >= ({1'b0, b} + (W+1)'(ce)));
            exp_v = (a[W-1] != b[W-1]) && (exp_r[W-1] != a[W-1]);
        end
        br = sub ? ~b : b;

        @(negedge clk);
        opa = a; opb = b; op_sub = sub; cin_ext = cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opa = $urandom; opb = $urandom; op_sub = 1'($urandom_range(0, 1)); cin_ext = 1'($urandom_range(0, 1));
        cyc = 1;
        while (done !== 1'b1 && cyc <= NB + 4) begin
            check("busy_run", busy, 1);
            if (cyc <= NB) begin
                check("add_a_limb", add_a, a[8*(cyc-1) +: 8]);
                check("add_b_limb", add_b, br[8*(cyc-1) +: 8]);
            end
            if (cyc == 1) check("add_cin_first", add_cin, sub ^ ce);
            start = (poke && cyc == 2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_latency", cyc, NB + 1);
        check("busy_done", busy, 1);
        check("result", result, exp_r);
        check("flag_c", flag_c, exp_c);
        check("flag_v", flag_v, exp_v);
        check("flag_z", flag_z, exp_r == '0);
        check("flag_n", flag_n, exp_r[W-1]);
        check("add_a_quiet", {add_a, add_b, 7'd0, add_cin}, 0);
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_end", done, 0);
        check("busy_end", busy, 0);
        if (poke) begin
            for (int i = 0; i < NB + 3; i++) begin
                @(posedge clk); #1;
                check("no_second_op", {busy, done}, 0);
            end
            check("result_held", result, exp_r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin_ext = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done", {busy, done}, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        check("rst_adder_if", {add_a, add_b, 7'd0, add_cin}, 0);
        @(negedge clk); rst = 1'b0;

        // Directed cases, including carry/overflow/zero/borrow corners.
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0);
        run_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0);
        check("sub_wrap_const", result, 32'h7FFFFFFF);

        // Extra starts in RUN and DONE must be ignored.
        run_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);

        // Reset in the second RUN cycle discards the operation.
        @(negedge clk);
        opa = 32'h11111111; opb = 32'h22222222; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy_done", {busy, done}, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", {flag_c, flag_v, flag_z, flag_n}, 0);
        check("midrst_adder_if", {add_a, add_b, 7'd0, add_cin}, 0);
        rst = 1'b0;
        for (int i = 0; i < NB + 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", done, 0);
        end
        run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef ADDER_SEQ_CARRY_IN_EN
        run_op(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0);
        check("adc_const", result, 32'h00000001);
        run_op(32'h00000005, 32'h00000002, 1'b1, 1'b1, 1'b0);
        check("sbb_const", result, 32'h00000002);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
